cpu_control_unit: RTL and testbench

- Multi-cycle sequencer for the 8-bit accumulator CPU.
- Owns the program counter and instruction register, and decodes 16-bit instructions from program memory.
- Generates the per-cycle enables and selects for the register file, ALU, accumulator and data memory.
- Sits between program memory and the datapath inside the cpu top level, replacing the free-running PC and direct opcode wiring.

---
 rtl/cpu_control_unit_pkg.sv | 70 +++++++
 rtl/cpu_control_unit_if.sv | 64 ++++++
 rtl/cpu_decoder.sv | 59 +++++
 rtl/cpu_control_unit.sv | 119 +++++++++++
 tb/tb_cpu_control_unit.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_control_unit_pkg.sv
// Shared types for the accumulator CPU control unit.
// Opcodes, ALU ops, sequencer states and the decoded control word.
package cpu_control_unit_pkg;

  localparam int CU_PC_W  = 5;
  localparam int CU_RF_AW = 3;
  localparam int CU_DW    = 8;
  localparam int CU_IW    = 16;

  typedef enum logic [4:0] {
    OP_NOP = 5'b00000,
    OP_LDI = 5'b00001,
    OP_LDR = 5'b00010,
    OP_STR = 5'b00011,
    OP_LDM = 5'b00100,
    OP_STM = 5'b00101,
    OP_JMP = 5'b00110,
    OP_JC  = 5'b00111,
    OP_JZ  = 5'b01000,
    OP_HLT = 5'b01111,
    OP_ADD = 5'b10000,
    OP_SUB = 5'b10001,
    OP_AND = 5'b10010,
    OP_OR  = 5'b10011,
    OP_XOR = 5'b10100,
    OP_NOT = 5'b10101,
    OP_SHL = 5'b10110,
    OP_SHR = 5'b10111
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOT,
    ALU_SHL,
    ALU_SHR
  } alu_op_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMWAIT,
    S_HALT
  } ctrl_state_t;

  localparam logic [1:0] ACC_ALU = 2'd0;
  localparam logic [1:0] ACC_RF  = 2'd1;
  localparam logic [1:0] ACC_DM  = 2'd2;
  localparam logic [1:0] ACC_IMM = 2'd3;

  typedef struct packed {
    logic       rf_we;
    logic       acc_ce;
    logic       dm_we;
    logic [1:0] acc_mux;
    alu_op_t    alu_op;
    logic       alu;
    logic       ldm;
    logic       hlt;
    logic       jmp;
    logic       jc;
    logic       jz;
    logic       illegal;
  } ctrl_word_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Program memory / datapath side of the control unit.
// master = sequencer, slave = datapath and program memory.
interface cpu_control_unit_if
  import cpu_control_unit_pkg::*;
#(
  parameter int PC_W  = CU_PC_W,
  parameter int RF_AW = CU_RF_AW,
  parameter int DW    = CU_DW
);

  logic             i_ce;
  logic [CU_IW-1:0] i_instr;
  logic             i_carry;
  logic [DW-1:0]    i_acc;

  logic [PC_W-1:0]  o_pc_addr;
  logic [RF_AW-1:0] o_rf_addr;
  logic             o_rf_we;
  logic             o_acc_ce;
  logic [1:0]       o_acc_mux;
  alu_op_t          o_alu_op;
  logic [DW-1:0]    o_dm_addr;
  logic             o_dm_we;
  logic [DW-1:0]    o_direct_data;
  logic             o_halted;
  logic             o_illegal;

  modport master (
    input  i_ce,
    input  i_instr,
    input  i_carry,
    input  i_acc,
    output o_pc_addr,
    output o_rf_addr,
    output o_rf_we,
    output o_acc_ce,
    output o_acc_mux,
    output o_alu_op,
    output o_dm_addr,
    output o_dm_we,
    output o_direct_data,
    output o_halted,
    output o_illegal
  );

  modport slave (
    output i_ce,
    output i_instr,
    output i_carry,
    output i_acc,
    input  o_pc_addr,
    input  o_rf_addr,
    input  o_rf_we,
    input  o_acc_ce,
    input  o_acc_mux,
    input  o_alu_op,
    input  o_dm_addr,
    input  o_dm_we,
    input  o_direct_data,
    input  o_halted,
    input  o_illegal
  );

endinterface

// File: rtl/cpu_decoder.sv
// Combinational opcode -> control word decode.
// Strobes here are raw; the sequencer gates them by state.
module cpu_decoder
  import cpu_control_unit_pkg::*;
(
  input  opcode_t    op,
  output ctrl_word_t cw
);

  always_comb begin
    cw         = '0;
    cw.acc_mux = ACC_ALU;
    cw.alu_op  = ALU_ADD;
    unique case (1'b1)
      op[4]: begin
        cw.alu    = 1'b1;
        cw.acc_ce = 1'b1;
        cw.alu_op = alu_op_t'(op[2:0]);
      end
      (op == OP_NOP): begin
      end
      (op == OP_LDI): begin
        cw.acc_ce  = 1'b1;
        cw.acc_mux = ACC_IMM;
      end
      (op == OP_LDR): begin
        cw.acc_ce  = 1'b1;
        cw.acc_mux = ACC_RF;
      end
      (op == OP_STR): begin
        cw.rf_we = 1'b1;
      end
      // load strobe comes one cycle later, in MEMWAIT
      (op == OP_LDM): begin
        cw.ldm     = 1'b1;
        cw.acc_mux = ACC_DM;
      end
      (op == OP_STM): begin
        cw.dm_we = 1'b1;
      end
      (op == OP_JMP): begin
        cw.jmp = 1'b1;
      end
      (op == OP_JC): begin
        cw.jc = 1'b1;
      end
      (op == OP_JZ): begin
        cw.jz = 1'b1;
      end
      (op == OP_HLT): begin
        cw.hlt = 1'b1;
      end
      default: begin
        cw.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer: owns PC, IR and carry flag,
// and emits per-cycle datapath strobes and selects.
module cpu_control_unit
  import cpu_control_unit_pkg::*;
#(
  parameter int PC_W  = CU_PC_W,
  parameter int RF_AW = CU_RF_AW,
  parameter int DW    = CU_DW
) (
  input logic                 i_clk,
  input logic                 i_rst,
  cpu_control_unit_if.master  bus
);

  ctrl_state_t      state_q;
  ctrl_state_t      state_d;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CU_IW-1:0] ir_q;
  logic [CU_IW-1:0] ir_d;
  logic             carry_q;
  logic             carry_d;

  opcode_t    op;
  ctrl_word_t cw;
  logic       taken;
  logic       rf_we;
  logic       acc_ce;
  logic       dm_we;
  logic       illegal;

  assign op = opcode_t'(ir_q[15:11]);

  cpu_decoder u_dec (
    .op (op),
    .cw (cw)
  );

  assign taken = cw.jmp
               | (cw.jc & carry_q)
               | (cw.jz & (bus.i_acc == '0));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    carry_d = carry_q;
    rf_we   = 1'b0;
    acc_ce  = 1'b0;
    dm_we   = 1'b0;
    illegal = 1'b0;
    if (bus.i_ce) begin
      unique case (state_q)
        S_FETCH: begin
          state_d = S_DECODE;
        end
        S_DECODE: begin
          ir_d    = bus.i_instr;
          state_d = S_EXECUTE;
        end
        S_EXECUTE: begin
          rf_we   = cw.rf_we;
          acc_ce  = cw.acc_ce;
          dm_we   = cw.dm_we;
          illegal = cw.illegal;
          if (cw.alu) carry_d = bus.i_carry;
          if (cw.hlt) begin
            state_d = S_HALT;
          end else if (cw.ldm) begin
            state_d = S_MEMWAIT;
          end else begin
            state_d = S_FETCH;
            pc_d    = taken ? ir_q[PC_W-1:0]
                            : pc_q + 1'b1;
          end
        end
        S_MEMWAIT: begin
          acc_ce  = 1'b1;
          state_d = S_FETCH;
          pc_d    = pc_q + 1'b1;
        end
        S_HALT: begin
        end
        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

  // reset is synchronous, so strobes must be masked in the reset cycle itself
  assign bus.o_rf_we   = rf_we & ~i_rst;
  assign bus.o_acc_ce  = acc_ce & ~i_rst;
  assign bus.o_dm_we   = dm_we & ~i_rst;
  assign bus.o_illegal = illegal & ~i_rst;

  assign bus.o_pc_addr     = pc_q;
  assign bus.o_rf_addr     = ir_q[8 +: RF_AW];
  assign bus.o_acc_mux     = cw.acc_mux;
  assign bus.o_alu_op      = cw.alu_op;
  assign bus.o_dm_addr     = ir_q[DW-1:0];
  assign bus.o_direct_data = ir_q[DW-1:0];
  assign bus.o_halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Bench for cpu_control_unit: directed programs, then random
// programs with random clock-enable stalls against an ISA-level model.
module tb_cpu_control_unit;

  localparam logic [4:0] NOP = 5'd0;
  localparam logic [4:0] LDI = 5'd1;
  localparam logic [4:0] LDR = 5'd2;
  localparam logic [4:0] STR = 5'd3;
  localparam logic [4:0] LDM = 5'd4;
  localparam logic [4:0] STM = 5'd5;
  localparam logic [4:0] JMP = 5'd6;
  localparam logic [4:0] JC  = 5'd7;
  localparam logic [4:0] JZ  = 5'd8;
  localparam logic [4:0] HLT = 5'd15;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  cpu_control_unit_if bus ();

  cpu_control_unit dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  logic [15:0] rom [32];

  // synchronous program memory: data valid the cycle after the address
  always @(posedge i_clk) bus.i_instr <= rom[bus.o_pc_addr];

  int   n_vec = 0;
  int   n_err = 0;
  int   m_pc = 0;
  bit   m_carry = 1'b0;
  bit   rand_io = 1'b0;
  bit   drv_carry = 1'b0;
  logic [7:0] drv_acc = 8'h00;
  int   p_stall = 0;
  int   stall_k = -1;
  int   stall_len = 0;
  int   abort_k = -1;
  bit   chk_rst = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {bus.o_rf_we, bus.o_acc_ce, bus.o_dm_we,
            bus.o_illegal, bus.o_halted};
  endfunction

  task automatic drive(input bit ce, input bit rst);
    @(negedge i_clk);
    i_rst    = rst;
    bus.i_ce = ce;
    if (rand_io) begin
      bus.i_carry = 1'($urandom_range(0, 1));
      bus.i_acc   = ($urandom_range(0, 3) == 0) ? 8'h00
                                                 : 8'($urandom);
    end else begin
      bus.i_carry = drv_carry;
      bus.i_acc   = drv_acc;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b1);
    chk("rst_cycle_strobes", {27'd0, strobes() & 5'b11110}, 32'd0);
    m_pc    = 0;
    m_carry = 1'b0;
    chk_rst = 1'b1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
  endtask

  // one whole instruction from its FETCH cycle, as the ISA describes it
  task automatic exec_instr();
    logic [15:0] ins;
    logic [4:0]  op;
    logic [2:0]  rfa;
    logic [7:0]  imm;
    logic [4:0]  exp;
    logic [1:0]  emux;
    bit          alu;
    bit          ill;
    bit          taken;
    bit          ce;
    int          n;
    int          k;
    ins   = rom[m_pc];
    op    = ins[15:11];
    rfa   = ins[10:8];
    imm   = ins[7:0];
    alu   = op[4];
    ill   = (op >= 5'd9) && (op <= 5'd14);
    n     = (op == LDM) ? 4 : 3;
    taken = 1'b0;
    k     = 0;
    while (k < n) begin
      if (k == abort_k) begin
        abort_k = -1;
        do_reset();
        return;
      end
      if (k == stall_k && stall_len > 0) begin
        ce = 1'b0;
        stall_len--;
      end else begin
        ce = ($urandom_range(0, 99) >= p_stall);
      end
      drive(ce, 1'b0);
      if (!ce) begin
        chk("stall_strobes", {27'd0, strobes()}, 32'd0);
        chk("stall_pc", 32'(bus.o_pc_addr), 32'(m_pc));
        continue;
      end
      if (k == 0) begin
        chk("fetch_pc", 32'(bus.o_pc_addr), 32'(m_pc));
        chk("fetch_strobes", {27'd0, strobes()}, 32'd0);
        if (chk_rst) begin
          chk("rst_selects",
              {27'd0, bus.o_acc_mux, bus.o_alu_op}, 32'd0);
          chk_rst = 1'b0;
        end
      end else if (k == 1) begin
        chk("decode_strobes", {27'd0, strobes()}, 32'd0);
      end else if (k == 2) begin
        exp = {op == STR, (op == LDI) || (op == LDR) || alu,
               op == STM, ill, 1'b0};
        chk("exec_strobes", {27'd0, strobes()}, {27'd0, exp});
        if (alu || op == LDI || op == LDR) begin
          emux = alu ? 2'd0 : (op == LDR) ? 2'd1 : 2'd3;
          chk("exec_mux", 32'(bus.o_acc_mux), 32'(emux));
        end
        if (alu)
          chk("exec_alu_op", 32'(bus.o_alu_op), 32'(op[2:0]));
        if (op == LDI)
          chk("exec_imm", 32'(bus.o_direct_data), 32'(imm));
        if (op == STR || op == LDR)
          chk("exec_rf_addr", 32'(bus.o_rf_addr), 32'(rfa));
        if (op == STM || op == LDM)
          chk("exec_dm_addr", 32'(bus.o_dm_addr), 32'(imm));
        taken = (op == JMP) || (op == JC && m_carry)
             || (op == JZ && bus.i_acc == 8'h00);
        if (alu) m_carry = bus.i_carry;
      end else begin
        chk("memwait_strobes", {27'd0, strobes()}, 32'h08);
        chk("memwait_mux", 32'(bus.o_acc_mux), 32'd2);
      end
      k++;
    end
    if (op == HLT) begin
      repeat (20) begin
        drive(1'($urandom_range(0, 1)), 1'b0);
        chk("halt_strobes", {27'd0, strobes()}, 32'h01);
        chk("halt_pc", 32'(bus.o_pc_addr), 32'(m_pc));
      end
      return;
    end
    m_pc = taken ? int'(imm[4:0]) : (m_pc + 1) % 32;
  endtask

  initial begin
    bus.i_ce    = 1'b1;
    bus.i_carry = 1'b0;
    bus.i_acc   = 8'h00;

    // straight-line program, LDM, carry jumps, PC wrap
    clear_rom();
    rom[0]  = 16'h0805;
    rom[1]  = 16'h1A00;
    rom[2]  = 16'h0803;
    rom[3]  = 16'h8200;
    rom[4]  = 16'h2010;
    rom[5]  = 16'h8100;
    rom[6]  = 16'h381A;
    rom[26] = 16'h8300;
    rom[27] = 16'h3805;
    rom[28] = 16'h301F;
    rom[31] = 16'h0000;
    rand_io = 1'b0;
    drv_acc = 8'h11;
    do_reset();
    repeat (5) exec_instr();
    drv_carry = 1'b1;
    exec_instr();
    drv_carry = 1'b0;
    repeat (6) exec_instr();

    // JZ, STM under stall, illegal opcode, self-loop
    clear_rom();
    rom[0] = 16'h4007;
    rom[7] = 16'h2842;
    rom[8] = 16'h5000;
    rom[9] = 16'h3009;
    do_reset();
    drv_acc = 8'h00;
    exec_instr();
    stall_k   = 2;
    stall_len = 4;
    exec_instr();
    stall_k = -1;
    drv_acc = 8'h5A;
    repeat (4) exec_instr();

    // halt, then reset out of HALT
    clear_rom();
    rom[0] = 16'h7800;
    do_reset();
    exec_instr();
    do_reset();
    rom[0] = 16'h0000;
    exec_instr();

    // reset in MEMWAIT and in EXECUTE
    rom[0] = 16'h2033;
    do_reset();
    abort_k = 3;
    exec_instr();
    exec_instr();
    do_reset();
    abort_k = 2;
    exec_instr();
    exec_instr();

    // random programs with random stalls
    rand_io = 1'b1;
    p_stall = 20;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) begin
        rom[i] = 16'($urandom);
        if (rom[i][15:11] == HLT) rom[i][15:11] = NOP;
      end
      do_reset();
      repeat (150) exec_instr();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
